// File: rtl/req_grant_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | req_grant_rr_arbiter                                                      |
// | Round-robin arbiter sharing one req/grant resource, with hang watchdog.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module req_grant_rr_arbiter #(
  parameter int REQ_N          = 4,
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = $clog2(REQ_N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQ_N-1:0]         s_req,
  output logic [REQ_N-1:0]         s_grant,
  output logic [PAYLOAD_WIDTH-1:0] s_payload,
  output logic [ID_W-1:0]          grant_id,
  output logic                     m_req,
  input  logic                     m_grant,
  input  logic [PAYLOAD_WIDTH-1:0] m_payload,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     timeout_clr
);

  localparam int               CNT_W     = 16;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ID_W-1:0]  C_LAST    = ID_W'(REQ_N - 1);
  localparam logic [ID_W:0]    C_REQ_N   = (ID_W + 1)'(REQ_N);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_next_rr_ptr;
  logic [ID_W-1:0]    r_sel;
  logic [ID_W-1:0]    w_next_sel;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_next_wait_cnt;
  logic               r_timeout_err;
  logic               w_timeout_set;
  logic [ID_W-1:0]    w_rr_sel;
  logic               w_rr_found;
  logic [ID_W:0]      w_idx;
  logic [ID_W-1:0]    w_sel;
  logic               w_m_req;

  function automatic logic [ID_W-1:0] f_next_ptr(input logic [ID_W-1:0] v);
    return (v == C_LAST) ? '0 : v + ID_W'(1);
  endfunction

  // First requester at or after r_rr_ptr, wrapping modulo REQ_N.
  always_comb begin
    w_rr_sel   = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < REQ_N; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
      if (w_idx >= C_REQ_N) begin
        w_idx = w_idx - C_REQ_N;
      end
      if (!w_rr_found && s_req[w_idx[ID_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = w_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_rr_ptr   = r_rr_ptr;
    w_next_sel      = r_sel;
    w_next_wait_cnt = r_wait_cnt;
    w_sel           = r_sel;
    w_m_req         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_m_req = w_rr_found;
        w_sel   = w_rr_sel;
        if (w_rr_found) begin
          if (m_grant) begin
            w_next_rr_ptr = f_next_ptr(w_rr_sel);
          end else begin
            w_next_state    = ST_LOCK;
            w_next_sel      = w_rr_sel;
            w_next_wait_cnt = CNT_W'(1);
          end
        end
      end
      ST_LOCK: begin
        w_m_req = 1'b1;
        w_sel   = r_sel;
        if (m_grant) begin
          w_next_rr_ptr   = f_next_ptr(r_sel);
          w_next_state    = ST_IDLE;
          w_next_wait_cnt = '0;
        end else if (r_wait_cnt < C_TIMEOUT) begin
          w_next_wait_cnt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Fire once as the counter arrives at the limit so a clear can stick while the lock persists.
  assign w_timeout_set = (w_next_wait_cnt == C_TIMEOUT) && (r_wait_cnt != C_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_sel         <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_rr_ptr   <= w_next_rr_ptr;
      r_sel      <= w_next_sel;
      r_wait_cnt <= w_next_wait_cnt;
      if (w_timeout_set) begin
        r_timeout_err <= 1'b1;
      end else if (timeout_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  // Outputs are gated by rst_n so they drop the instant reset is asserted.
  assign m_req       = w_m_req & rst_n;
  assign grant_id    = rst_n ? w_sel : '0;
  assign s_grant     = (m_req && m_grant) ? ({{(REQ_N-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign s_payload   = m_payload;
  assign busy        = (r_state == ST_LOCK);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_req_grant_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_req_grant_rr_arbiter                                                   |
// | Scoreboard bench: reference model predicts, negedge monitor compares.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_req_grant_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] s_req = '0;
  logic [N-1:0] s_grant;
  logic [W-1:0] s_payload;
  logic [1:0]   grant_id;
  logic         m_req;
  logic         m_grant = 1'b0;
  logic [W-1:0] m_payload = '0;
  logic         busy;
  logic         timeout_err;
  logic         timeout_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         m_req;
    logic [N-1:0] grant;
    logic [1:0]   id;
    logic         busy;
    logic         err;
    logic [W-1:0] payload;
  } exp_t;

  exp_t exp_q[$];
  logic [N-1:0] last_grant = '0;

  // Reference model state
  bit mlock, merr;
  int mptr, mowner, mwcnt;

  req_grant_rr_arbiter #(
    .REQ_N(N), .PAYLOAD_WIDTH(W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_req(s_req), .s_grant(s_grant),
    .s_payload(s_payload), .grant_id(grant_id), .m_req(m_req),
    .m_grant(m_grant), .m_payload(m_payload), .busy(busy),
    .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mlock = 0; merr = 0; mptr = 0; mowner = 0; mwcnt = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int s;
    int nw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nw = mwcnt;
    if (!mlock) begin
      s = pick(s_req);
      if (s >= 0) begin
        if (m_grant) mptr = (s + 1) % N;
        else begin mlock = 1; mowner = s; nw = 1; end
      end
    end else if (m_grant) begin
      mptr = (mowner + 1) % N; mlock = 0; nw = 0;
    end else if (mwcnt < TO) begin
      nw = mwcnt + 1;
    end
    if (nw == TO && mwcnt != TO) merr = 1;
    else if (timeout_clr) merr = 0;
    mwcnt = nw;
  endtask

  task automatic push_expected();
    exp_t e;
    int s;
    e = '0;
    if (rst_n) begin
      if (!mlock) begin
        s = pick(s_req);
        e.m_req = (s >= 0);
        e.id    = (s >= 0) ? 2'(s) : 2'd0;
        e.grant = (s >= 0 && m_grant) ? N'(1 << s) : '0;
      end else begin
        e.m_req = 1'b1;
        e.id    = 2'(mowner);
        e.grant = m_grant ? N'(1 << mowner) : '0;
        e.busy  = 1'b1;
      end
      e.err = merr;
    end
    e.payload  = m_payload;
    last_grant = e.grant;
    exp_q.push_back(e);
  endtask

  task automatic repush();
    void'(exp_q.pop_back());
    push_expected();
  endtask

  task automatic cyc(input logic [N-1:0] req, input logic mg, input logic [W-1:0] pl,
                     input logic clr);
    @(posedge clk);
    model_step();
    #1;
    s_req = req; m_grant = mg; m_payload = pl; timeout_clr = clr;
    push_expected();
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("m_req", 64'(m_req), 64'(e.m_req));
      chk("s_grant", 64'(s_grant), 64'(e.grant));
      if (e.m_req) chk("grant_id", 64'(grant_id), 64'(e.id));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("timeout_err", 64'(timeout_err), 64'(e.err));
      if (e.grant != '0) chk("s_payload", 64'(s_payload), 64'(e.payload));
      if (busy && rst_n) chk("protocol_hold", 64'(s_req[grant_id]), 64'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] nreq;
    model_reset();
    s_req = 4'b1111;
    m_grant = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", 64'(m_req), 0);
    chk("rst_s_grant", 64'(s_grant), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chk("rst_err", 64'(timeout_err), 0);
    rst_n = 1'b1; s_req = '0; m_grant = 1'b0;

    // All requesting, immediate grants: 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1111, 1'b1, W'(k), 1'b0);
      chk("rr_order", 64'(s_grant), 64'(1 << (k % 4)));
    end
    // Single requester, zero-latency transfer
    cyc(4'b0010, 1'b1, 32'h100, 1'b0);
    chk("single_grant", 64'(s_grant), 64'h2);
    chk("single_payload", 64'(s_payload), 64'h100);
    chk("single_busy", 64'(busy), 0);
    // Lock hold on requester 2 while requester 0 arrives
    cyc(4'b0100, 1'b0, 32'h0, 1'b0);
    cyc(4'b0100, 1'b0, 32'h0, 1'b0);
    chk("lock_busy1", 64'(busy), 1);
    chk("lock_id1", 64'(grant_id), 2);
    cyc(4'b0101, 1'b0, 32'h0, 1'b0);
    chk("lock_id2", 64'(grant_id), 2);
    cyc(4'b0101, 1'b1, 32'h22, 1'b0);
    chk("lock_grant", 64'(s_grant), 64'h4);
    cyc(4'b0001, 1'b1, 32'h33, 1'b0);
    chk("after_lock", 64'(s_grant), 64'h1);
    // Wrap-around from pointer 3
    cyc(4'b0100, 1'b1, 32'h44, 1'b0);
    cyc(4'b1001, 1'b1, 32'h55, 1'b0);
    chk("wrap_first", 64'(s_grant), 64'h8);
    cyc(4'b1001, 1'b1, 32'h66, 1'b0);
    chk("wrap_second", 64'(s_grant), 64'h1);
    cyc(4'b1111, 1'b0, 32'h0, 1'b0);
    chk("wrap_ptr1", 64'(grant_id), 1);
    cyc(4'b1111, 1'b1, 32'h77, 1'b0);
    // Watchdog: resource never grants
    cyc(4'b0001, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(4'b0001, 1'b0, 32'h0, 1'b0);
      chk("wd_err", 64'(timeout_err), 64'(k >= TO));
    end
    cyc(4'b0001, 1'b0, 32'h0, 1'b1);
    cyc(4'b0001, 1'b0, 32'h0, 1'b0);
    chk("wd_cleared", 64'(timeout_err), 0);
    chk("wd_still_busy", 64'(busy), 1);
    cyc(4'b0001, 1'b1, 32'hAB, 1'b0);
    chk("wd_late_grant", 64'(s_grant), 64'h1);
    // Asynchronous reset while locked
    cyc(4'b0010, 1'b0, 32'h0, 1'b0);
    cyc(4'b0010, 1'b1, 32'h0, 1'b0);
    chk("pre_rst_busy", 64'(busy), 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_m_req", 64'(m_req), 0);
    chk("arst_s_grant", 64'(s_grant), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_id", 64'(grant_id), 0);
    repush();
    cyc(4'b1111, 1'b0, 32'h0, 1'b0);
    cyc(4'b1111, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    repush();
    cyc(4'b1111, 1'b1, 32'h99, 1'b0);
    chk("post_rst_grant", 64'(s_grant), 64'h1);

    // Random phase: requests held until granted
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        nreq[i] = (s_req[i] && !last_grant[i]) ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
      cyc(nreq, ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 49) == 0));
    end
    cyc('0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
